// File: rtl/uart_tx_multibyte.sv
// Purpose : UART transmitter that serialises a NUM_BYTES-character word as back-to-back
//           start/data/(parity)/stop frames, most-significant character first, LSB first per character.
// Latency : first start-bit cycle on tx is the cycle after the load edge; done pulses one cycle after the last stop bit.
// Backpressure: in_ready is high only in IDLE; in_valid while busy is ignored and the word in flight is untouched.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset (async assert, sync release expected from outside)
//   in_valid  word on data_in is valid
//   in_ready  block can accept a word (IDLE)
//   data_in   NUM_BYTES*DATA_BITS word, character [W-1 -: DATA_BITS] sent first
//   tx        serial line, idle high
//   busy      high from the cycle after load until the last stop bit completes
//   done      one-cycle pulse after the final stop bit of the word

module uart_tx_multibyte #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int NUM_BYTES  = 4,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_BYTES*DATA_BITS-1:0] data_in,
    output logic                           tx,
    output logic                           busy,
    output logic                           done
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int WORD_W       = NUM_BYTES * DATA_BITS;

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = (DATA_BITS > 1)    ? $clog2(DATA_BITS)    : 1;
    localparam int CHAR_W = (NUM_BYTES > 1)    ? $clog2(NUM_BYTES)    : 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(NUM_BYTES - 1);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    localparam logic HAS_PARITY = (PARITY_EN != 0);
    localparam logic ODD_PARITY = (PARITY_ODD != 0);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity checks
    // ------------------------------------------------------------------
    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx_multibyte: CLKS_PER_BIT must be >= 2");
        end
        if (NUM_BYTES < 1) begin : g_bad_bytes
            $error("uart_tx_multibyte: NUM_BYTES must be >= 1");
        end
        if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
            $error("uart_tx_multibyte: DATA_BITS must be 5..8");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_multibyte: STOP_BITS must be 1 or 2");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [BAUD_W-1:0]   baud_cnt;   // cycle within the current bit period
    logic [BIT_W-1:0]    bit_cnt;    // data bit index within the character
    logic                stop_cnt;   // stop bit index (only reaches 1 with two stop bits)
    logic [CHAR_W-1:0]   char_cnt;   // character index within the word
    logic [WORD_W-1:0]   word_q;     // current character always sits in the top DATA_BITS
    logic                done_q;

    logic                baud_last;
    logic                bit_last;
    logic                stop_last;
    logic                char_last;
    logic                load;
    logic                char_end;

    logic [DATA_BITS-1:0] cur_char;
    logic                 parity_bit;

    assign baud_last = (baud_cnt == BAUD_LAST);
    assign bit_last  = (bit_cnt  == BIT_LAST);
    assign stop_last = (stop_cnt == STOP_LAST);
    assign char_last = (char_cnt == CHAR_LAST);

    assign load      = in_valid && (state == S_IDLE);

    // Last cycle of the last stop bit of a character.
    assign char_end  = (state == S_STOP) && baud_last && stop_last;

    assign cur_char   = word_q[WORD_W-1 -: DATA_BITS];
    assign parity_bit = (^cur_char) ^ ODD_PARITY;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last && bit_last) begin
                    state_nxt = HAS_PARITY ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (char_end) begin
                    state_nxt = char_last ? S_IDLE : S_START;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // tx is decoded from registered state so an async reset forces the
    // line high in the same cycle without waiting for a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        tx       = 1'b1;
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_START:  tx = 1'b0;
            S_DATA:   tx = cur_char[bit_cnt];
            S_PARITY: tx = parity_bit;
            S_STOP:   tx = 1'b1;
            default: begin
                tx   = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

    assign done = done_q;

    // ------------------------------------------------------------------
    // Counters, shift register and done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            char_cnt <= '0;
            word_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            // Done fires in the IDLE cycle that follows the final stop bit.
            done_q <= (state == S_STOP) && (state_nxt == S_IDLE);

            // Baud counter restarts on every state change and on every bit
            // boundary inside multi-bit states (DATA, two-bit STOP).
            if ((state_nxt != state) || baud_last) begin
                baud_cnt <= '0;
            end else if (state != S_IDLE) begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            if (state != S_DATA) begin
                bit_cnt <= '0;
            end else if (baud_last) begin
                bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
            end

            if (state != S_STOP) begin
                stop_cnt <= 1'b0;
            end else if (baud_last) begin
                stop_cnt <= stop_last ? 1'b0 : 1'b1;
            end

            if (state == S_IDLE) begin
                char_cnt <= '0;
            end else if (char_end && !char_last) begin
                char_cnt <= char_cnt + 1'b1;
            end

            // Load only in IDLE; afterwards data_in is ignored. Each finished
            // character is shifted out of the top so the next one is in place
            // for its start bit.
            if (load) begin
                word_q <= data_in;
            end else if (char_end && !char_last) begin
                word_q <= word_q << DATA_BITS;
            end
        end
    end

endmodule
